// File: rtl/fp_accum_seq.sv
// Initiator-side sequencer that folds a stream of IEEE-754 singles through a multi-cycle adder.
// Optional watchdog on the adder handshake is enabled with the FP_ACC_TIMEOUT_EN macro.
module fp_accum_seq #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             add_start,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    input  logic             add_done,
    output logic [31:0]      acc_out,
    output logic             acc_valid,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_IN   = 3'd1,
        S_ISSUE     = 3'd2,
        S_ARM       = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [31:0]      acc_r;
    logic [31:0]      add_a_r;
    logic [31:0]      add_b_r;
    logic [31:0]      acc_out_r;
    logic             acc_valid_r;
    logic             add_start_r;
    logic             in_ready_r;
    logic             busy_r;
    logic             err_r;
    logic             accept_s;
    logic             bypass_s;
    logic             last_s;
    logic             acc_zero_s;
    logic             timeout_s;

    assign cnt_inc_s  = cnt_r + CNT_W'(1);
    assign last_s     = (cnt_inc_s == len_r);
    assign accept_s   = (state_r == S_WAIT_IN) && in_valid && in_ready_r;
    // The adder forces the hidden bit, so any zero operand must skip it.
    assign acc_zero_s = (acc_r[30:0] == 31'd0);
    assign bypass_s   = (cnt_r == CNT_W'(0)) || (in_data[30:0] == 31'd0) || acc_zero_s;

`ifdef FP_ACC_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [WD_W-1:0] wd_r;

    // Watchdog: counts cycles spent in WAIT_DONE, zero on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state_r == S_WAIT_DONE) begin
            wd_r <= wd_r + WD_W'(1);
        end else begin
            wd_r <= {WD_W{1'b0}};
        end
    end

    assign timeout_s = (state_r == S_WAIT_DONE) && !add_done &&
                       (wd_r == WD_W'(TIMEOUT_CYC - 1));
`else
    // No watchdog: the handshake may wait forever, so the abort path never fires.
    assign timeout_s = (TIMEOUT_CYC < 0);
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (go) begin
                    state_s = (cfg_len == CNT_W'(0)) ? S_FINISH : S_WAIT_IN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT_IN: begin
                if (accept_s) begin
                    if (bypass_s) begin
                        state_s = last_s ? S_FINISH : S_WAIT_IN;
                    end else begin
                        state_s = S_ISSUE;
                    end
                end else begin
                    state_s = S_WAIT_IN;
                end
            end
            S_ISSUE: begin
                state_s = S_ARM;
            end
            // A stale done from the previous transaction may still be visible here.
            S_ARM: begin
                state_s = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (add_done) begin
                    state_s = last_s ? S_FINISH : S_WAIT_IN;
                end else if (timeout_s) begin
                    state_s = S_FINISH;
                end else begin
                    state_s = S_WAIT_DONE;
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register, registered handshake outputs and accumulator datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            len_r       <= CNT_W'(0);
            cnt_r       <= CNT_W'(0);
            acc_r       <= 32'h0000_0000;
            add_a_r     <= 32'h0000_0000;
            add_b_r     <= 32'h0000_0000;
            acc_out_r   <= 32'h0000_0000;
            acc_valid_r <= 1'b0;
            add_start_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == S_WAIT_IN);
            add_start_r <= (state_s == S_ISSUE);
            busy_r      <= (state_s != S_IDLE);
            acc_valid_r <= (state_r == S_FINISH);
            case (state_r)
                S_IDLE: begin
                    if (go) begin
                        len_r <= cfg_len;
                        cnt_r <= CNT_W'(0);
                        acc_r <= 32'h0000_0000;
                        err_r <= 1'b0;
                    end
                end
                S_WAIT_IN: begin
                    if (accept_s) begin
                        if (bypass_s) begin
                            if (acc_zero_s) begin
                                acc_r <= in_data;
                            end
                            cnt_r <= cnt_inc_s;
                        end else begin
                            // Operands are loaded here so they are valid together with start.
                            add_a_r <= acc_r;
                            add_b_r <= in_data;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (add_done) begin
                        acc_r <= add_sum;
                        cnt_r <= cnt_inc_s;
                    end else if (timeout_s) begin
                        err_r <= 1'b1;
                    end
                end
                S_FINISH: begin
                    acc_out_r <= acc_r;
                end
                default: begin
                    acc_out_r <= acc_out_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign add_start = add_start_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign acc_out   = acc_out_r;
    assign acc_valid = acc_valid_r;
    assign busy      = busy_r;
    assign err       = err_r;

endmodule

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Initiator-side sequencer for the multi-cycle FP adder start/done protocol.
- Accepts a stream of IEEE-754 single-precision values and issues one adder transaction per element.
- Holds adder operands stable for the whole transaction, folds each returned sum into a running accumulator, and reports the final sum once.
- Sits between a data source (valid/ready) and one adder instance; the adder is the responder.

Parameters:
- CNT_W, 8, width of element count; max length 2^CNT_W-1.
- TIMEOUT_CYC, 255, cycles allowed in WAIT_DONE before abort (used only with FP_ACC_TIMEOUT_EN).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- go  input  1  start pulse; sampled in IDLE only.
- cfg_len  input  CNT_W  number of elements; sampled with go.
- in_valid  input  1  source element valid.
- in_data  input  32  source element, IEEE-754 single.
- in_ready  output  1  high only in WAIT_IN.
- add_start  output  1  one-cycle pulse to adder.
- add_a  output  32  adder operand a (accumulator).
- add_b  output  32  adder operand b (element).
- add_sum  input  32  adder result.
- add_done  input  1  adder done; level, cleared by adder on start.
- acc_out  output  32  final accumulated sum.
- acc_valid  output  1  one-cycle pulse when acc_out is updated.
- busy  output  1  high in every state except IDLE.
- err  output  1  timeout flag (tied 0 without FP_ACC_TIMEOUT_EN).

Behaviour:
- Reset values: in_ready=0, add_start=0, add_a=0, add_b=0, acc_out=0, acc_valid=0, busy=0, err=0. Internal acc=0, cnt=0, state=IDLE.
- States: IDLE, WAIT_IN, ISSUE, ARM, WAIT_DONE, FINISH.
- IDLE:
  - On go, latch cfg_len into len, clear acc/cnt/err.
  - len==0 -> FINISH with acc=32'h0.
  - Otherwise -> WAIT_IN.
  - go outside IDLE is ignored.
- WAIT_IN:
  - in_ready=1. On in_valid&&in_ready, capture in_data as x.
  - Bypass, no adder transaction: if cnt==0, or x[30:0]==0 (signed zero), or acc[30:0]==0. The result is acc<=x when acc is zero, else acc unchanged. Then cnt++; if cnt+1==len -> FINISH, else stay in WAIT_IN.
  - Bypass is required because the adder forces the hidden bit and never detects zero operands.
  - Otherwise -> ISSUE.
- ISSUE:
  - add_a<=acc, add_b<=x, add_start=1 for exactly this cycle.
  - Operands are driven before or with start, then held constant until leaving WAIT_DONE, since the adder reads its input ports after start.
- ARM:
  - One cycle; add_done is ignored because a stale done from the previous transaction may still be visible.
  - -> WAIT_DONE.
- WAIT_DONE:
  - On add_done==1: acc<=add_sum, cnt++.
  - cnt+1==len -> FINISH, else -> WAIT_IN.
- FINISH:
  - acc_out<=acc, acc_valid=1 for one cycle, -> IDLE.
  - acc_out holds its value until the next FINISH.
- Latency:
  - go to first in_ready: 1 cycle.
  - Per non-bypassed element: in_valid accept -> acc update = 2 + adder latency cycles.
  - Per bypassed element: 1 cycle.
  - Last element to acc_valid: 1 cycle.
- Adder NaN/Inf results are passed through unmodified.
- Reset mid-transaction: return to IDLE immediately, add_start=0, partial result discarded, acc_out cleared. The adder is reset by its own reset.
- add_done high in IDLE/WAIT_IN/ISSUE/ARM: ignored.
- in_valid outside WAIT_IN: not accepted.

Optional Feature:
- Macro: FP_ACC_TIMEOUT_EN.
- With the macro:
  - 8-bit+ watchdog counts cycles in WAIT_DONE and clears on entry.
  - On reaching TIMEOUT_CYC without add_done: err<=1, -> FINISH, with acc_out = accumulator before the failed transaction.
  - err stays high until the next accepted go or reset.
- Without the macro: no counter, err tied 0, WAIT_DONE waits indefinitely.

Test Plan:
- Bench responder with 5-cycle latency returning the exact IEEE sum. cfg_len=3, inputs 3F800000, 40000000, 40400000 -> acc_out=40C00000 (6.0), one acc_valid pulse, exactly 2 add_start pulses (first element bypassed).
- cfg_len=0, go -> acc_valid on the 2nd cycle after go, acc_out=00000000, no add_start, in_ready never high.
- cfg_len=2, inputs 40A00000, 80000000 (-0.0) -> no add_start, acc_out=40A00000.
- Responder holds add_done=1 from the previous transaction. Check add_done is ignored in ARM and add_a/add_b stay stable from ISSUE until done. Inputs 3F800000, BF800000 -> acc_out matches the responder's returned sum.
- Assert reset during WAIT_DONE -> next cycle busy=0, add_start=0, acc_out=0. A subsequent go with len=1, input 41200000 -> acc_out=41200000.
- FP_ACC_TIMEOUT_EN defined, TIMEOUT_CYC=16, responder never raises done -> err=1 and acc_valid pulse after 16 WAIT_DONE cycles, acc_out = the pre-transaction accumulator.
